// File: rtl/fpu_pkg.sv
// Shared FP32 constants, exception bit positions, rounding modes and the
// accumulator state type.
package fpu_pkg;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

  // Exception vector bit positions, ordered {NV, DZ, OF, UF, NX}
  localparam int unsigned EXC_NV = 4;
  localparam int unsigned EXC_DZ = 3;
  localparam int unsigned EXC_OF = 2;
  localparam int unsigned EXC_UF = 1;
  localparam int unsigned EXC_NX = 0;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} acc_state_t;

  // Leading-zero count of a 27-bit significand (27 when all zero)
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Operand-in / result-out valid/ready bundle of the FP32 accumulator.
interface fp_accumulator_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic [2:0]       round_mode;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [4:0]       out_exceptions;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_sub, in_last, round_mode, out_ready,
    input  in_ready, out_valid, out_data, out_exceptions, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, round_mode, out_ready,
    output in_ready, out_valid, out_data, out_exceptions, out_count
  );

endinterface

// File: rtl/add_sub.sv
// Combinational IEEE-754 binary32 adder/subtractor with all five rounding
// modes and {NV, DZ, OF, UF, NX} flags. NaN results are the canonical qNaN.
module add_sub
  import fpu_pkg::*;
(
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic        operation,
  input  logic [2:0]  round_mode,
  output logic [31:0] out_z,
  output logic [4:0]  exceptions
);

  logic        sx, sy;
  logic [7:0]  ex, ey;
  logic [22:0] fx, fy;
  logic        x_nan, y_nan, x_snan, y_snan, x_inf, y_inf;
  logic        x_ge_y, sa, sb, eff_sub;
  logic [7:0]  ea, eb, ea_eff, eb_eff, diff;
  logic [26:0] ma, mb, mb_sh;
  logic [27:0] raw;
  logic [4:0]  lz;
  logic [9:0]  shamt, exp_n, exp_r;
  logic [26:0] norm;
  logic        round_up, inexact;
  logic [24:0] mant_r;
  logic [22:0] frac;
  logic [7:0]  exp_enc;

  // The y sign is flipped for subtraction so the datapath only ever adds
  assign sx = in_x[31];
  assign sy = in_y[31] ^ operation;
  assign ex = in_x[30:23];
  assign ey = in_y[30:23];
  assign fx = in_x[22:0];
  assign fy = in_y[22:0];

  assign x_nan  = (ex == 8'hFF) && (fx != 23'd0);
  assign y_nan  = (ey == 8'hFF) && (fy != 23'd0);
  assign x_snan = x_nan & ~fx[22];
  assign y_snan = y_nan & ~fy[22];
  assign x_inf  = (ex == 8'hFF) && (fx == 23'd0);
  assign y_inf  = (ey == 8'hFF) && (fy == 23'd0);

  // Operand a is the larger magnitude, so a - b never goes negative
  assign x_ge_y  = in_x[30:0] >= in_y[30:0];
  assign sa      = x_ge_y ? sx : sy;
  assign sb      = x_ge_y ? sy : sx;
  assign ea      = x_ge_y ? ex : ey;
  assign eb      = x_ge_y ? ey : ex;
  assign ea_eff  = (ea == 8'd0) ? 8'd1 : ea;
  assign eb_eff  = (eb == 8'd0) ? 8'd1 : eb;
  assign ma      = {ea != 8'd0, (x_ge_y ? fx : fy), 3'b000};
  assign mb      = {eb != 8'd0, (x_ge_y ? fy : fx), 3'b000};
  assign diff    = ea_eff - eb_eff;
  assign eff_sub = sa ^ sb;

  // Align b to a, folding shifted-out bits into the sticky bit
  always_comb begin
    mb_sh = mb >> diff;
    if (diff >= 8'd27) begin
      mb_sh = {26'd0, |mb};
    end else if ((mb_sh << diff) != mb) begin
      mb_sh[0] = 1'b1;
    end
  end

  assign raw = eff_sub ? ({1'b0, ma} - {1'b0, mb_sh}) : ({1'b0, ma} + {1'b0, mb_sh});
  assign lz  = lzc27(raw[26:0]);

  // Normalize (left shift limited so results can land in the subnormal range) and round
  always_comb begin
    shamt = 10'd0;
    norm  = raw[26:0];
    exp_n = {2'b00, ea_eff};
    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      exp_n = {2'b00, ea_eff} + 10'd1;
    end else begin
      shamt = ({5'd0, lz} > ({2'b00, ea_eff} - 10'd1)) ? ({2'b00, ea_eff} - 10'd1)
                                                        : {5'd0, lz};
      norm  = raw[26:0] << shamt;
      exp_n = {2'b00, ea_eff} - shamt;
    end

    inexact = |norm[2:0];
    case (round_mode)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = inexact & sa;
      RM_RUP:  round_up = inexact & ~sa;
      RM_RMM:  round_up = norm[2];
      RM_RNE:  round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      default: round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    endcase

    mant_r  = {1'b0, norm[26:3]} + {24'd0, round_up};
    exp_r   = mant_r[24] ? (exp_n + 10'd1) : exp_n;
    frac    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    // A subnormal that rounds up into bit 23 becomes the smallest normal
    exp_enc = (mant_r[24] | mant_r[23]) ? exp_r[7:0] : 8'd0;
  end

  // Special-case selection and final packing
  always_comb begin
    out_z              = FP32_POS_ZERO;
    exceptions         = 5'd0;
    exceptions[EXC_DZ] = 1'b0;
    if (x_nan | y_nan) begin
      out_z              = FP32_QNAN;
      exceptions[EXC_NV] = x_snan | y_snan;
    end else if (x_inf & y_inf & (sx ^ sy)) begin
      out_z              = FP32_QNAN;
      exceptions[EXC_NV] = 1'b1;
    end else if (x_inf) begin
      out_z = {sx, 8'hFF, 23'd0};
    end else if (y_inf) begin
      out_z = {sy, 8'hFF, 23'd0};
    end else if (raw == 28'd0) begin
      // Exact cancellation gives +0 except when rounding down
      out_z = {(eff_sub ? (round_mode == RM_RDN) : sa), 31'd0};
    end else if (exp_r >= 10'd255) begin
      exceptions[EXC_OF] = 1'b1;
      exceptions[EXC_NX] = 1'b1;
      case (round_mode)
        RM_RTZ:  out_z = {sa, 8'hFE, 23'h7F_FFFF};
        RM_RDN:  out_z = sa ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7F_FFFF};
        RM_RUP:  out_z = sa ? {1'b1, 8'hFE, 23'h7F_FFFF} : {1'b0, 8'hFF, 23'd0};
        default: out_z = {sa, 8'hFF, 23'd0};
      endcase
    end else begin
      out_z              = {sa, exp_enc, frac};
      exceptions[EXC_NX] = inexact;
      exceptions[EXC_UF] = inexact & ~norm[26];
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// FP32 running-sum accumulator: adds one operand per accepted beat into a
// registered sum through a single add_sub, and presents the sum, sticky flags
// and beat count when the beat tagged last has been accepted.
module fp_accumulator
  import fpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  fp_accumulator_if.slave bus
);

  acc_state_t       state_q, state_d;
  logic [31:0]      sum_q, sum_d;
  logic [4:0]       flags_q, flags_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready, accept;
  logic [31:0]      add_z;
  logic [4:0]       add_exc;

  assign in_ready = (state_q != HOLD);
  assign accept   = bus.in_valid & in_ready;

  add_sub u_add_sub (
    .in_x       (sum_q),
    .in_y       (bus.in_data),
    .operation  (bus.in_sub),
    .round_mode (bus.round_mode),
    .out_z      (add_z),
    .exceptions (add_exc)
  );

  // Next-state: accumulate on accepted beats, clear on the result handshake
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    flags_d = flags_q;
    count_d = count_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          sum_d   = add_z;
          flags_d = flags_q | add_exc;
          if (count_q != '1) count_d = count_q + CNT_W'(1);
          state_d = bus.in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          sum_d   = FP32_POS_ZERO;
          flags_d = 5'd0;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= FP32_POS_ZERO;
      flags_q <= 5'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  // Handshake outputs decode the state register only
  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_q == HOLD);
  assign bus.out_data       = sum_q;
  assign bus.out_exceptions = flags_q;
  assign bus.out_count      = count_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: expected results are queued as each packet
// is driven and popped when the DUT presents its result.
module tb_fp_accumulator;
  import fpu_pkg::*;

  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_accumulator_if #(.CNT_W(CW)) bus ();

  fp_accumulator #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0]   data;
    logic [4:0]    exc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [31:0] d, input logic [4:0] x, input logic [CW-1:0] c);
    exp_t e;
    e.data = d;
    e.exc  = x;
    e.cnt  = c;
    sb_q.push_back(e);
  endtask

  // Present one beat and hold it until the edge that accepts it
  task automatic beat(input logic [31:0] d, input logic sub, input logic last,
                      input logic [2:0] rm);
    int n;
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.in_sub     = sub;
    bus.in_last    = last;
    bus.round_mode = rm;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("in_ready_timeout", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_sub   = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait for a result, compare against the scoreboard head, check the pulse width
  task automatic collect(input string tag);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    e = sb_q.pop_front();
    chk({tag, "_data"}, bus.out_data, e.data);
    chk({tag, "_exc"}, 32'(bus.out_exceptions), 32'(e.exc));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(e.cnt));
    if (bus.out_ready) begin
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.out_valid), 0);
      chk({tag, "_rdy_back"}, 32'(bus.in_ready), 1);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'd0;
    bus.in_sub     = 1'b0;
    bus.in_last    = 1'b0;
    bus.round_mode = RM_RNE;
    bus.out_ready  = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_exc", 32'(bus.out_exceptions), 0);
    chk("rst_out_count", 32'(bus.out_count), 0);
    tick();
    rst = 1'b0;

    // 1 + 2 + 3 = 6
    expect_res(32'h40C0_0000, 5'b00000, 3'd3);
    beat(32'h3F80_0000, 1'b0, 1'b0, RM_RNE);
    beat(32'h4000_0000, 1'b0, 1'b0, RM_RNE);
    beat(32'h4040_0000, 1'b0, 1'b1, RM_RNE);
    collect("basic");

    // +inf + -inf is invalid
    expect_res(32'h7FC0_0000, 5'b10000, 3'd2);
    beat(32'h7F80_0000, 1'b0, 1'b0, RM_RNE);
    beat(32'hFF80_0000, 1'b0, 1'b1, RM_RNE);
    collect("invalid");

    // max + max overflows: inf under RNE, max finite under RTZ
    expect_res(32'h7F80_0000, 5'b00101, 3'd2);
    beat(32'h7F7F_FFFF, 1'b0, 1'b0, RM_RNE);
    beat(32'h7F7F_FFFF, 1'b0, 1'b1, RM_RNE);
    collect("ovf_rne");
    expect_res(32'h7F7F_FFFF, 5'b00101, 3'd2);
    beat(32'h7F7F_FFFF, 1'b0, 1'b0, RM_RTZ);
    beat(32'h7F7F_FFFF, 1'b0, 1'b1, RM_RTZ);
    collect("ovf_rtz");

    // 1 + 2^-24 is an exact tie: RNE keeps 1.0, RUP bumps the lsb
    expect_res(32'h3F80_0000, 5'b00001, 3'd2);
    beat(32'h3F80_0000, 1'b0, 1'b0, RM_RNE);
    beat(32'h3380_0000, 1'b0, 1'b1, RM_RNE);
    collect("tie_rne");
    expect_res(32'h3F80_0001, 5'b00001, 3'd2);
    beat(32'h3F80_0000, 1'b0, 1'b0, RM_RUP);
    beat(32'h3380_0000, 1'b0, 1'b1, RM_RUP);
    collect("tie_rup");

    // 3 - 1 = 2
    expect_res(32'h4000_0000, 5'b00000, 3'd2);
    beat(32'h4040_0000, 1'b0, 1'b0, RM_RNE);
    beat(32'h3F80_0000, 1'b1, 1'b1, RM_RNE);
    collect("sub");

    // Nine beats of 1.0: sum 9.0, 3-bit count saturates at 7
    expect_res(32'h4110_0000, 5'b00000, 3'd7);
    for (int i = 0; i < 9; i++) beat(32'h3F80_0000, 1'b0, (i == 8), RM_RNE);
    collect("sat");

    // Backpressure: result held, extra beats ignored
    expect_res(32'h4080_0000, 5'b00000, 3'd2);
    bus.out_ready = 1'b0;
    beat(32'h4000_0000, 1'b0, 1'b0, RM_RNE);
    beat(32'h4000_0000, 1'b0, 1'b1, RM_RNE);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F80_0000;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_data", bus.out_data, 32'h4080_0000);
      chk("bp_count", 32'(bus.out_count), 2);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    collect("bp");
    expect_res(32'h4040_0000, 5'b00000, 3'd1);
    beat(32'h4040_0000, 1'b0, 1'b1, RM_RNE);
    collect("bp_next");

    // Reset mid-packet discards the partial sum
    beat(32'h4000_0000, 1'b0, 1'b0, RM_RNE);
    beat(32'h4000_0000, 1'b0, 1'b0, RM_RNE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_data", bus.out_data, 32'h0);
    chk("midrst_count", 32'(bus.out_count), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    tick();
    expect_res(32'h3F80_0000, 5'b00000, 3'd1);
    beat(32'h3F80_0000, 1'b0, 1'b1, RM_RNE);
    collect("midrst");

    // Reset while holding a result drops it
    bus.out_ready = 1'b0;
    beat(32'h3F80_0000, 1'b0, 1'b1, RM_RNE);
    @(negedge clk);
    chk("holdrst_pre", 32'(bus.out_valid), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("holdrst_valid", 32'(bus.out_valid), 0);
    chk("holdrst_data", bus.out_data, 32'h0);
    bus.out_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential FP32 accumulator that sits directly downstream of the `add_sub` combinational adder and drives it in a feedback loop. A neuron's product stream arrives one operand per beat on a valid/ready interface. The block keeps a registered running sum, feeding `sum` and the incoming operand into one `add_sub` instance. On the beat tagged last, it presents the final sum together with sticky IEEE exception flags on an output valid/ready interface.

## Interface
Parameters:
- `CNT_W`, default 16: width of the beat counter reported with each result.

Ports:
- `clk`  in  1: the block's only clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block can accept a beat.
- `in_data`  in  32: FP32 operand.
- `in_sub`  in  1: 1 = subtract operand from the running sum, 0 = add. Maps to `add_sub` `operation`.
- `in_last`  in  1: final beat of the current packet.
- `round_mode`  in  3: IEEE rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM). Sampled on every accepted beat.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  32: final FP32 sum.
- `out_exceptions`  out  5: sticky OR of per-beat flags, ordered {NV, DZ, OF, UF, NX}.
- `out_count`  out  CNT_W: number of beats accepted in the packet; saturates at all-ones.

## Operation
- States: `IDLE` (no beat accepted since the last result), `ACC` (at least one beat accepted), `HOLD` (result presented).
- `in_ready` = 1 in `IDLE` and `ACC`, and 0 in `HOLD`.
- **Accepted beat** (`in_valid & in_ready`):
  - `sum <= add_sub(in_x=sum, in_y=in_data, operation=in_sub, round_mode)`.
  - `flags <= flags | exceptions`.
  - `count <= count + 1`, saturating at all-ones.
- **State transitions:**
  - `IDLE` → `ACC` on an accepted beat without `in_last`.
  - `IDLE` or `ACC` → `HOLD` on an accepted beat with `in_last`. A single-beat packet is legal; its result is `0 + in_data` as computed by `add_sub`.
  - `HOLD` → `IDLE` when `out_ready` is high. On that same edge, `sum` clears to `32'h0000_0000`, and `flags` and `count` clear to 0.
- In `HOLD`, `out_valid` = 1 and `out_data`, `out_exceptions` and `out_count` are stable until the handshake completes.
- NaN or infinity in the running sum propagates through `add_sub` unchanged. No special handling is added here.
- Arithmetic is exactly `add_sub`'s. The block performs no extra rounding, normalization or flag masking.
- `in_valid` with `in_ready` low is ignored. The producer must hold the beat until it is accepted.

## Timing
- Reset values: `sum` = +0, flags = 0, count = 0, state = `IDLE`.
- Output reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_exceptions` = 0, `out_count` = 0.
- Throughput: one beat per cycle. The `add_sub` path is a single combinational stage, and `sum` is its only feedback register.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, so the result is visible in the following cycle.
- Back-to-back packets:
  - The first beat of the next packet can be accepted one cycle after the output handshake, once `IDLE` is reached.
  - There is no beat acceptance in the handshake cycle itself, because `in_ready` = 0 in `HOLD`.
- `rst` asserted in any state, including mid-packet or in `HOLD`, discards the partial sum on the next edge and returns all registers to their reset values. `rst` has priority over any simultaneous handshake.
- Outputs are registered. `in_ready` and `out_valid` are decoded from the state register only, with no combinational path from `out_ready`.

## Structure
- Shared package `fpu_pkg`:
  - FP32 constants: `FP32_POS_ZERO` = `32'h0`, `FP32_QNAN` = `32'h7FC0_0000`.
  - Exception bit indices: `EXC_NV` = 4, `EXC_DZ` = 3, `EXC_OF` = 2, `EXC_UF` = 1, `EXC_NX` = 0.
  - Rounding-mode constants 0 to 4.
  - State enum `acc_state_t {IDLE, ACC, HOLD}`.
- Sub-module: a single `add_sub` instance. No other sub-modules; the FSM, counter and flag register are inline. Expected size is about 150 lines of RTL.

## Test plan
- **Basic sum:** beats `3F80_0000`, `4000_0000`, `4040_0000` (last), RNE, `out_ready` = 1 → `out_data` = `40C0_0000`, `out_exceptions` = 0, `out_count` = 3, `out_valid` high for exactly 1 cycle.
- **Invalid operation:** beats `7F80_0000`, `FF80_0000` (last) → `out_data` = `7FC0_0000`, `out_exceptions[4]` = 1.
- **Overflow:** beats `7F7F_FFFF`, `7F7F_FFFF` (last), RNE → `out_data` = `7F80_0000`, `out_exceptions` = `5'b00101`. The same stimulus with RTZ → `out_data` = `7F7F_FFFF`.
- **Backpressure:** `out_ready` held low for 5 cycles after the last beat → outputs stable, `in_ready` = 0, `in_valid` beats ignored. `out_ready` then high → `IDLE` next cycle, and a following single-beat packet `4040_0000` yields `4040_0000` with count 1.
- **Subtraction:** beats `4040_0000` add, `3F80_0000` with `in_sub` = 1 (last) → `out_data` = `4000_0000`.
- **Reset mid-packet:** two beats accepted, then `rst` for 1 cycle → next packet `3F80_0000` (last) yields `3F80_0000`, count 1, flags 0.
